seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It double-buffers a packed vector of 5-bit glyph codes and scans one digit per scan period. It decodes each code to active-low segments and supports per-digit blinking. It sits between the game/score logic and the board display pins and replaces per-digit combinational decoders with a single shared decoder.

---
 rtl/seven_seg_pkg.sv | 38 +++
 rtl/seven_seg_scan_driver_rom.sv | 43 ++++
 rtl/seven_seg_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the seven-segment scan driver: digit
//                code width, named glyph codes and the active-high segment
//                pattern for every defined glyph.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    localparam int DIGIT_W = 5;

    localparam logic [DIGIT_W-1:0] GLYPH_C     = 5'd10;
    localparam logic [DIGIT_W-1:0] GLYPH_P     = 5'd11;
    localparam logic [DIGIT_W-1:0] GLYPH_R     = 5'd12;
    localparam logic [DIGIT_W-1:0] GLYPH_BLANK = 5'd31;

    // Active-high glyph patterns, one bit per segments_n line. The weights
    // follow the board's segment wiring: bit0..bit6 drive the bottom,
    // lower-left, upper-left, top, upper-right, lower-right and middle bars.
    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h30;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h79;
    localparam logic [6:0] SEG_PAT_4 = 7'h74;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h6F;
    localparam logic [6:0] SEG_PAT_7 = 7'h38;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h7D;
    localparam logic [6:0] SEG_PAT_C = 7'h0F;
    localparam logic [6:0] SEG_PAT_P = 7'h5E;
    localparam logic [6:0] SEG_PAT_R = 7'h42;

    localparam logic [6:0] SEG_OFF_N = 7'h7F;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_scan_driver_rom.sv
`default_nettype none
// ============================================================================
//  Module      : seg_glyph_rom
//  Description : Combinational glyph decoder. Maps a 5-bit glyph code to
//                active-low segment drive; undefined codes give all segments
//                off.
//  Ports       : i_code       - glyph code
//                o_segments_n - active-low segment lines
//  Revision    : 1.0  initial release
// ============================================================================
module seg_glyph_rom
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_code,
    output logic [6:0]         o_segments_n
);

    logic [6:0] w_pat;

    always_comb begin
        w_pat = 7'h00;
        case (i_code)
            5'd0:    w_pat = SEG_PAT_0;
            5'd1:    w_pat = SEG_PAT_1;
            5'd2:    w_pat = SEG_PAT_2;
            5'd3:    w_pat = SEG_PAT_3;
            5'd4:    w_pat = SEG_PAT_4;
            5'd5:    w_pat = SEG_PAT_5;
            5'd6:    w_pat = SEG_PAT_6;
            5'd7:    w_pat = SEG_PAT_7;
            5'd8:    w_pat = SEG_PAT_8;
            5'd9:    w_pat = SEG_PAT_9;
            GLYPH_C: w_pat = SEG_PAT_C;
            GLYPH_P: w_pat = SEG_PAT_P;
            GLYPH_R: w_pat = SEG_PAT_R;
            default: w_pat = 7'h00;
        endcase
    end

    assign o_segments_n = ~w_pat;

endmodule : seg_glyph_rom
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Time-multiplexed common-anode seven-segment driver with a
//                double-buffered digit register, one shared glyph decoder
//                and per-digit blinking.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                enable         - display on; low blanks and parks the scan
//                load           - strobe capturing digits_in (pending buffer)
//                digits_in      - packed 5-bit codes, digit 0 in the LSBs
//                blink_mask     - per-digit blink enable (sampled live)
//                segments_n     - active-low segment lines
//                anodes_n       - active-low digit selects
//                frame_done     - pulse on the first output cycle of digit 0
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    output logic [6:0]                    segments_n,
    output logic [NUM_DIGITS-1:0]         anodes_n,
    output logic                          frame_done
);

    localparam int c_presc_w = $clog2(SCAN_DIV);
    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_frm_w   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_buf_w   = DIGIT_W * NUM_DIGITS;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_frm_w-1:0]   c_frm_last   = c_frm_w'(BLINK_FRAMES - 1);
    localparam logic [c_buf_w-1:0]   c_buf_blank  = {NUM_DIGITS{GLYPH_BLANK}};

    logic [c_presc_w-1:0]  r_presc;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_frm_w-1:0]    r_frm;
    logic                  r_phase;
    logic                  r_wrapped;
    logic [c_buf_w-1:0]    r_disp;
    logic [c_buf_w-1:0]    r_pend;
    logic                  r_pend_valid;
    logic [6:0]            r_seg_n;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_done;

    logic                  w_tick;
    logic                  w_wrap;
    logic [DIGIT_W-1:0]    w_code;
    logic                  w_blink_sel;
    logic [NUM_DIGITS-1:0] w_an_sel_n;
    logic [6:0]            w_seg_n;

    assign w_tick = enable && (r_presc == c_presc_last);
    assign w_wrap = w_tick && (r_idx == c_idx_last);

    // Scan timing: prescaler, digit index and blink frame counter. All of
    // them are parked at zero while the display is disabled so that the
    // scan restarts at digit 0 when enable rises again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_frm     <= '0;
            r_phase   <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (!enable) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_frm     <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= w_wrap;
            r_presc   <= w_tick ? '0 : r_presc + c_presc_w'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            end
            if (w_wrap) begin
                if (r_frm == c_frm_last) begin
                    r_frm   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frm <= r_frm + c_frm_w'(1);
                end
            end
        end
    end

    // Double buffer: the display register only changes on a frame wrap so a
    // frame never shows a mix of old and new digits. A load landing exactly
    // on the wrap bypasses the pending stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp       <= c_buf_blank;
            r_pend       <= c_buf_blank;
            r_pend_valid <= 1'b0;
        end else if (load && w_wrap) begin
            r_disp       <= digits_in;
            r_pend       <= digits_in;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_wrap && r_pend_valid) begin
                r_disp       <= r_pend;
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend       <= digits_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Select the current digit's code, blink bit and anode line.
    always_comb begin
        w_code      = GLYPH_BLANK;
        w_blink_sel = 1'b0;
        w_an_sel_n  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_code        = r_disp[i*DIGIT_W +: DIGIT_W];
                w_blink_sel   = blink_mask[i];
                w_an_sel_n[i] = 1'b0;
            end
        end
    end

    seg_glyph_rom u_rom (
        .i_code       (w_code),
        .o_segments_n (w_seg_n)
    );

    // Registered pin drivers. r_wrapped delays the wrap by one cycle so that
    // frame_done lines up with the first registered output of digit 0.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_seg_n      <= SEG_OFF_N;
            r_an_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg_n      <= w_seg_n;
            r_an_n       <= (r_phase && w_blink_sel) ? '1 : w_an_sel_n;
            r_frame_done <= r_wrapped;
        end
    end

    assign segments_n = r_seg_n;
    assign anodes_n   = r_an_n;
    assign frame_done = r_frame_done;

endmodule : seven_seg_scan_driver
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_driver
//  Description : Directed bench for seven_seg_scan_driver with NUM_DIGITS=4,
//                SCAN_DIV=4, BLINK_FRAMES=2. Each table row describes one
//                digit slot (4 clocks) of the scan: an optional load and the
//                outputs expected in that slot.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int N_SLOTS      = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [19:0] digits_in;
    logic [3:0]  blink_mask;
    logic [6:0]  segments_n;
    logic [3:0]  anodes_n;
    logic        frame_done;

    int n_vec = 0;
    int n_bad = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .blink_mask (blink_mask),
        .segments_n (segments_n),
        .anodes_n   (anodes_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ld_cyc;   // cycle of the slot carrying load, -1 = none
        logic [19:0] ld_val;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;       // frame_done expected on the slot's first cycle
    } slot_t;

    slot_t tbl [N_SLOTS];

    localparam logic [19:0] V_CPR8 = {5'd12, 5'd11, 5'd10, 5'd8};
    localparam logic [19:0] V_5555 = {5'd5, 5'd5, 5'd5, 5'd5};
    localparam logic [19:0] V_9999 = {5'd9, 5'd9, 5'd9, 5'd9};

    task automatic check(input string tag, input logic [3:0] an,
                         input logic [6:0] seg, input logic fd);
        n_vec++;
        if (anodes_n !== an || segments_n !== seg || frame_done !== fd) begin
            n_bad++;
            $display("FAIL %s: anodes_n=%b segments_n=%h frame_done=%b, expected %b %h %b",
                     tag, anodes_n, segments_n, frame_done, an, seg, fd);
        end
    endtask

    task automatic step_check(input string tag, input logic [3:0] an,
                              input logic [6:0] seg, input logic fd);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check(tag, an, seg, fd);
    endtask

    task automatic run_slot(input string tag, input int ld_cyc,
                            input logic [19:0] ld_val, input logic [3:0] an,
                            input logic [6:0] seg, input logic fd);
        for (int c = 0; c < SCAN_DIV; c++) begin
            if (c == ld_cyc) begin
                load      = 1'b1;
                digits_in = ld_val;
            end
            step_check($sformatf("%s c%0d", tag, c), an, seg, (c == 0) ? fd : 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frames 0..5 with blink_mask=0001: phase is 1 in frames 2-3.
        // F0: blank scan; load C/P/r/8 during digit 1.
        tbl[0]  = '{-1, 20'h0,   4'hE, 7'h7F, 1'b0};
        tbl[1]  = '{ 0, V_CPR8,  4'hD, 7'h7F, 1'b0};
        tbl[2]  = '{-1, 20'h0,   4'hB, 7'h7F, 1'b0};
        tbl[3]  = '{-1, 20'h0,   4'h7, 7'h7F, 1'b0};
        // F1: decoded glyphs; two loads, the second must win next frame.
        tbl[4]  = '{-1, 20'h0,   4'hE, 7'h00, 1'b1};
        tbl[5]  = '{ 0, 20'h1,   4'hD, 7'h70, 1'b0};
        tbl[6]  = '{ 0, 20'h2,   4'hB, 7'h21, 1'b0};
        tbl[7]  = '{-1, 20'h0,   4'h7, 7'h3D, 1'b0};
        // F2: code 2 on digit 0 (anode blinked off), code 0 elsewhere.
        tbl[8]  = '{-1, 20'h0,   4'hF, 7'h24, 1'b1};
        tbl[9]  = '{-1, 20'h0,   4'hD, 7'h40, 1'b0};
        tbl[10] = '{-1, 20'h0,   4'hB, 7'h40, 1'b0};
        tbl[11] = '{-1, 20'h0,   4'h7, 7'h40, 1'b0};
        // F3: pending 5s, then 9s loaded on the wrap cycle itself.
        tbl[12] = '{-1, 20'h0,   4'hF, 7'h24, 1'b1};
        tbl[13] = '{-1, 20'h0,   4'hD, 7'h40, 1'b0};
        tbl[14] = '{ 0, V_5555,  4'hB, 7'h40, 1'b0};
        tbl[15] = '{ 3, V_9999,  4'h7, 7'h40, 1'b0};
        // F4, F5: 9s everywhere, blink phase back to 0.
        tbl[16] = '{-1, 20'h0,   4'hE, 7'h02, 1'b1};
        tbl[17] = '{-1, 20'h0,   4'hD, 7'h02, 1'b0};
        tbl[18] = '{-1, 20'h0,   4'hB, 7'h02, 1'b0};
        tbl[19] = '{-1, 20'h0,   4'h7, 7'h02, 1'b0};
        tbl[20] = '{-1, 20'h0,   4'hE, 7'h02, 1'b1};
        tbl[21] = '{-1, 20'h0,   4'hD, 7'h02, 1'b0};
        tbl[22] = '{-1, 20'h0,   4'hB, 7'h02, 1'b0};
        tbl[23] = '{-1, 20'h0,   4'h7, 7'h02, 1'b0};

        reset      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        digits_in  = 20'h0;
        blink_mask = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 4'hF, 7'h7F, 1'b0);

        reset      = 1'b0;
        enable     = 1'b1;
        blink_mask = 4'b0001;
        check("release cycle", 4'hF, 7'h7F, 1'b0);

        for (int s = 0; s < N_SLOTS; s++) begin
            run_slot($sformatf("F%0dD%0d", s / 4, s % 4), tbl[s].ld_cyc,
                     tbl[s].ld_val, tbl[s].an, tbl[s].seg, tbl[s].fd);
        end

        n_vec++;
        if (dut.r_pend_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pend_valid after wrap load: got %b expected 0", dut.r_pend_valid);
        end

        // Frame 6: drop enable in the second cycle of digit 2.
        blink_mask = 4'b0000;
        run_slot("F6D0", -1, 20'h0, 4'hE, 7'h02, 1'b1);
        run_slot("F6D1", -1, 20'h0, 4'hD, 7'h02, 1'b0);
        step_check("F6D2 c0", 4'hB, 7'h02, 1'b0);
        enable = 1'b0;
        step_check("disabled 0", 4'hF, 7'h7F, 1'b0);
        load      = 1'b1;
        digits_in = 20'h0;
        for (int k = 1; k < 6; k++) begin
            step_check($sformatf("disabled %0d", k), 4'hF, 7'h7F, 1'b0);
        end

        // Re-enable: scan restarts at digit 0 with no frame_done; the load
        // taken while disabled shows up after the next wrap.
        enable = 1'b1;
        run_slot("R0D0", -1, 20'h0, 4'hE, 7'h02, 1'b0);
        run_slot("R0D1", -1, 20'h0, 4'hD, 7'h02, 1'b0);
        run_slot("R0D2", -1, 20'h0, 4'hB, 7'h02, 1'b0);
        run_slot("R0D3", -1, 20'h0, 4'h7, 7'h02, 1'b0);
        run_slot("R1D0", -1, 20'h0, 4'hE, 7'h40, 1'b1);

        // Reset mid-frame with a load pending: nothing may survive.
        load      = 1'b1;
        digits_in = 20'h8;
        step_check("R1D1 c0", 4'hD, 7'h40, 1'b0);
        step_check("R1D1 c1", 4'hD, 7'h40, 1'b0);
        reset = 1'b1;
        step_check("mid reset", 4'hF, 7'h7F, 1'b0);
        n_vec++;
        if (dut.r_pend_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pend_valid after reset: got %b expected 0", dut.r_pend_valid);
        end
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_slot($sformatf("X%0dD0", f), -1, 20'h0, 4'hE, 7'h7F, (f == 1));
            run_slot($sformatf("X%0dD1", f), -1, 20'h0, 4'hD, 7'h7F, 1'b0);
            run_slot($sformatf("X%0dD2", f), -1, 20'h0, 4'hB, 7'h7F, 1'b0);
            run_slot($sformatf("X%0dD3", f), -1, 20'h0, 4'h7, 7'h7F, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_seven_seg_scan_driver
`default_nettype wire
